// File: rtl/serial_pattern_sequencer.sv
// Purpose: loads a word, rotates it out LSB-first on prescaled ticks, counts "0 then 1" matches.
// Latency: first bit shift 2**DIV_WIDTH clocks after start, done one cycle after the last shift.
// Backpressure: none; start is sampled only in IDLE, abort cancels a run, done is a 1-cycle pulse.
module serial_pattern_sequencer #(
  parameter int WIDTH     = 10,
  parameter int DIV_WIDTH = 25,
  parameter int CNT_WIDTH = 4
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic                     abort,
  input  logic [WIDTH-1:0]         load_data,
  output logic                     busy,
  output logic                     done,
  output logic                     serial_out,
  output logic [WIDTH-1:0]         shift_data,
  output logic [$clog2(WIDTH)-1:0] bit_index,
  output logic                     match,
  output logic [CNT_WIDTH-1:0]     match_count
);

  localparam int IDX_W = $clog2(WIDTH);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  // S0: waiting for a 0, S1: saw a 0, S2: saw "0 then 1" (match)
  localparam logic [1:0] DET_S0 = 2'd0;
  localparam logic [1:0] DET_S1 = 2'd1;
  localparam logic [1:0] DET_S2 = 2'd2;

  logic [1:0]           state;
  logic [1:0]           det_state;
  logic [1:0]           det_next;
  logic [DIV_WIDTH-1:0] prescaler;
  logic                 tick;
  logic                 last_bit;
  logic                 cnt_full;

  assign tick       = (state == ST_SHIFT) && (prescaler == {DIV_WIDTH{1'b1}});
  assign last_bit   = (bit_index == IDX_W'(WIDTH - 1));
  assign cnt_full   = (match_count == {CNT_WIDTH{1'b1}});
  assign busy       = (state == ST_SHIFT);
  assign done       = (state == ST_DONE);
  assign serial_out = shift_data[0];

  // Detector next state for the bit currently presented on serial_out
  always_comb begin
    det_next = DET_S0;
    case (det_state)
      DET_S0:  det_next = shift_data[0] ? DET_S0 : DET_S1;
      DET_S1:  det_next = shift_data[0] ? DET_S2 : DET_S1;
      DET_S2:  det_next = shift_data[0] ? DET_S0 : DET_S1;
      default: det_next = DET_S0;
    endcase
  end

  // Run control, rotating shift register, prescaler and match counting
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      shift_data  <= '0;
      bit_index   <= '0;
      prescaler   <= '0;
      det_state   <= DET_S0;
      match       <= 1'b0;
      match_count <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            shift_data  <= load_data;
            bit_index   <= '0;
            prescaler   <= '0;
            det_state   <= DET_S0;
            match       <= 1'b0;
            match_count <= '0;
            state       <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (abort) begin
            // Partial results stay visible; a coincident tick is dropped
            state <= ST_IDLE;
          end else begin
            prescaler <= prescaler + DIV_WIDTH'(1);
            if (tick) begin
              // Rotate so the word is restored after WIDTH ticks
              shift_data <= {shift_data[0], shift_data[WIDTH-1:1]};
              det_state  <= det_next;
              match      <= (det_next == DET_S2);
              bit_index  <= bit_index + IDX_W'(1);
              if ((det_next == DET_S2) && !cnt_full) begin
                match_count <= match_count + CNT_WIDTH'(1);
              end
              if (last_bit) begin
                state <= ST_DONE;
              end
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_pattern_sequencer.sv
// Bench for serial_pattern_sequencer: WIDTH=10, DIV_WIDTH=2 (tick every 4 clocks).
// A second instance with CNT_WIDTH=2 shares all inputs to observe counter saturation.
module tb_serial_pattern_sequencer;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [9:0] load_data = '0;

  logic       busy, done, serial_out, match;
  logic [9:0] shift_data;
  logic [3:0] bit_index;
  logic [3:0] match_count;

  logic       s_busy, s_done, s_serial_out, s_match;
  logic [9:0] s_shift_data;
  logic [3:0] s_bit_index;
  logic [1:0] s_match_count;

  int checks = 0;
  int errors = 0;

  // Scoreboard: expected serial bits and expected final counts
  bit q_bits[$];
  int q_cnt[$];

  serial_pattern_sequencer #(.WIDTH(10), .DIV_WIDTH(2), .CNT_WIDTH(4)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .abort(abort), .load_data(load_data),
    .busy(busy), .done(done), .serial_out(serial_out), .shift_data(shift_data),
    .bit_index(bit_index), .match(match), .match_count(match_count)
  );

  serial_pattern_sequencer #(.WIDTH(10), .DIV_WIDTH(2), .CNT_WIDTH(2)) dut_sat (
    .clock(clock), .reset_n(reset_n), .start(start), .abort(abort), .load_data(load_data),
    .busy(s_busy), .done(s_done), .serial_out(s_serial_out), .shift_data(s_shift_data),
    .bit_index(s_bit_index), .match(s_match), .match_count(s_match_count)
  );

  always #5 clock = ~clock;

  function automatic logic [9:0] rotr(input logic [9:0] w, input int n);
    logic [9:0] r;
    r = w;
    repeat (n) r = {r[0], r[9:1]};
    return r;
  endfunction

  task automatic test_reset();
    #12;
    checks++;
    if ({busy, done, serial_out, match} !== 4'b0000 || shift_data !== 10'd0 ||
        bit_index !== 4'd0 || match_count !== 4'd0 || s_match_count !== 2'd0) begin
      errors++;
      $display("FAIL reset_values: busy=%b done=%b ser=%b match=%b sd=%b bi=%0d mc=%0d smc=%0d, want all zero",
               busy, done, serial_out, match, shift_data, bit_index, match_count, s_match_count);
    end
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
  endtask

  // Full run of one word; checks stream order, timing, counts and word restoration
  task automatic test_run_word(input logic [9:0] word, input int exp_cnt, input int exp_sat,
                               input string name);
    int   busy_cycles, done_idx, done_pulses, match_rises;
    logic prev_match;
    logic [3:0] prev_bi;
    bit   exp_b;
    int   exp_mc, exp_smc;
    for (int i = 0; i <= 10; i++) q_bits.push_back(word[i % 10]);
    q_cnt.push_back(exp_cnt);
    q_cnt.push_back(exp_sat);
    @(negedge clock);
    load_data = word;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    busy_cycles = 0; done_idx = -1; done_pulses = 0; match_rises = 0;
    prev_match = match;
    prev_bi = bit_index;
    exp_b = q_bits.pop_front();
    checks++;
    if (serial_out !== exp_b || bit_index !== 4'd0) begin
      errors++;
      $display("FAIL %s first_bit: ser=%b bi=%0d, want ser=%b bi=0", name, serial_out, bit_index, exp_b);
    end
    for (int idx = 0; idx < 50; idx++) begin
      if (idx > 0) @(negedge clock);
      if (busy) busy_cycles++;
      if (done) begin
        done_pulses++;
        if (done_idx < 0) done_idx = idx;
      end
      if (match && !prev_match) match_rises++;
      prev_match = match;
      if (bit_index !== prev_bi) begin
        prev_bi = bit_index;
        checks++;
        if (q_bits.size() == 0) begin
          errors++;
          $display("FAIL %s extra_shift: bi=%0d at idx %0d, want no further shifts", name, bit_index, idx);
        end else begin
          exp_b = q_bits.pop_front();
          if (serial_out !== exp_b) begin
            errors++;
            $display("FAIL %s stream: ser=%b at bi=%0d, want %b", name, serial_out, bit_index, exp_b);
          end
        end
      end
    end
    exp_mc = q_cnt.pop_front();
    exp_smc = q_cnt.pop_front();
    checks++;
    if (q_bits.size() != 0) begin
      errors++;
      $display("FAIL %s bits_left: %0d unshifted bits, want 0", name, q_bits.size());
      q_bits.delete();
    end
    checks++;
    if (busy_cycles != 40) begin
      errors++;
      $display("FAIL %s busy_len: %0d cycles, want 40", name, busy_cycles);
    end
    checks++;
    if (done_idx != 40 || done_pulses != 1) begin
      errors++;
      $display("FAIL %s done_timing: first at %0d, pulses %0d, want at 40, pulses 1", name, done_idx, done_pulses);
    end
    checks++;
    if (shift_data !== word) begin
      errors++;
      $display("FAIL %s restored: sd=%b, want %b", name, shift_data, word);
    end
    checks++;
    if (match_count !== 4'(exp_mc) || match_rises != exp_mc) begin
      errors++;
      $display("FAIL %s match_count: cnt=%0d rises=%0d, want %0d", name, match_count, match_rises, exp_mc);
    end
    checks++;
    if (s_match_count !== 2'(exp_smc)) begin
      errors++;
      $display("FAIL %s sat_count: %0d, want %0d", name, s_match_count, exp_smc);
    end
  endtask

  task automatic test_patterns();
    test_run_word(10'b10_0000_0000, 1, 1, "single_one");
    test_run_word(10'b10_1010_1010, 5, 3, "alt_even");
    test_run_word(10'b11_1111_1111, 0, 0, "all_ones");
    test_run_word(10'b01_0101_0101, 4, 3, "alt_odd");
  endtask

  task automatic test_abort();
    logic [9:0] word;
    int done_seen;
    word = 10'b11_0011_0101;
    @(negedge clock);
    load_data = word;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    // Ticks land at idx 4 and 8; idx 11 is the third tick cycle
    for (int idx = 1; idx <= 11; idx++) @(negedge clock);
    checks++;
    if (bit_index !== 4'd2 || !busy) begin
      errors++;
      $display("FAIL abort_pre: bi=%0d busy=%b, want bi=2 busy=1", bit_index, busy);
    end
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || bit_index !== 4'd2 || shift_data !== rotr(word, 2)) begin
      errors++;
      $display("FAIL abort_state: busy=%b bi=%0d sd=%b, want busy=0 bi=2 sd=%b",
               busy, bit_index, shift_data, rotr(word, 2));
    end
    done_seen = 0;
    for (int i = 0; i < 45; i++) begin
      @(negedge clock);
      if (done || busy) done_seen++;
    end
    checks++;
    if (done_seen != 0 || bit_index !== 4'd2) begin
      errors++;
      $display("FAIL abort_after: done/busy seen %0d cycles bi=%0d, want 0 cycles bi=2", done_seen, bit_index);
    end
  endtask

  task automatic test_start_ignored();
    logic [9:0] wa, wb;
    wa = 10'b00_1100_0110;
    wb = 10'b11_0101_1001;
    @(negedge clock);
    load_data = wa;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    for (int idx = 0; idx <= 42; idx++) begin
      if (idx > 0) @(negedge clock);
      if (idx == 20) begin
        checks++;
        if (shift_data !== rotr(wa, 5) || !busy) begin
          errors++;
          $display("FAIL ignore_mid: sd=%b busy=%b, want sd=%b busy=1", shift_data, busy, rotr(wa, 5));
        end
      end
      if (idx == 40) begin
        checks++;
        if (done !== 1'b1 || shift_data !== wa) begin
          errors++;
          $display("FAIL ignore_done: done=%b sd=%b, want done=1 sd=%b", done, shift_data, wa);
        end
      end
      if (idx == 41) begin
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
          errors++;
          $display("FAIL relaunch_idle: done=%b busy=%b, want 0 0", done, busy);
        end
      end
      if (idx == 42) begin
        checks++;
        if (busy !== 1'b1 || shift_data !== wb || bit_index !== 4'd0) begin
          errors++;
          $display("FAIL relaunch: busy=%b sd=%b bi=%0d, want busy=1 sd=%b bi=0", busy, shift_data, bit_index, wb);
        end
      end
      if (idx == 10) begin
        load_data = wb;
        start = 1'b1;
      end
      if (idx == 11) start = 1'b0;
      if (idx == 30) start = 1'b1;
    end
    start = 1'b0;
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    @(negedge clock);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL relaunch_abort: busy=%b, want 0", busy);
    end
  endtask

  task automatic test_reset_midrun();
    @(negedge clock);
    load_data = 10'b10_1010_1010;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    for (int idx = 1; idx <= 17; idx++) @(negedge clock);
    reset_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, serial_out, match} !== 4'b0000 || shift_data !== 10'd0 ||
        bit_index !== 4'd0 || match_count !== 4'd0 || s_match_count !== 2'd0) begin
      errors++;
      $display("FAIL reset_midrun: busy=%b done=%b ser=%b match=%b sd=%b bi=%0d mc=%0d, want all zero",
               busy, done, serial_out, match, shift_data, bit_index, match_count);
    end
    @(negedge clock);
    reset_n = 1'b1;
    test_run_word(10'b10_0000_0000, 1, 1, "after_reset");
  endtask

  initial begin
    test_reset();
    test_patterns();
    test_abort();
    test_start_ignored();
    test_reset_midrun();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
